// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, controller FSM states and default datapath width
package cpu_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
endpackage

// File: rtl/cpu_alu_comb.sv
// cpu_alu_comb: single-cycle ADD/SUB/logic/NOT with carry and overflow; shift codes pass a through with C=0
module cpu_alu_comb
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             v
);
  logic [WIDTH:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // the extra top bit of dif is the borrow, set exactly when a < b unsigned
  always_comb begin
    r = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        {c, r} = sum;
        v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        {c, r} = dif;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOT: r = ~a;
      default: r = a;
    endcase
  end
endmodule

// File: rtl/cpu_alu_flags.sv
// cpu_alu_flags: multi-cycle ALU with registered result and C/V/S/Z flags; ALU_ROTATE_EN turns shifts into rotates
module cpu_alu_flags
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       fsel,
  input  logic [2:0]       count,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             C,
  output logic             V,
  output logic             S,
  output logic             Z
);
`ifdef ALU_ROTATE_EN
  localparam logic ROT = 1'b1;
`else
  localparam logic ROT = 1'b0;
`endif
  state_t state, nxt;
  logic [WIDTH-1:0] la, lb, alu_r, sh_r, fin_r;
  logic [2:0] lf, cnt;
  logic alu_c, alu_v, sh_c, is_shift;
  cpu_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op(lf),
    .a (la),
    .b (lb),
    .r (alu_r),
    .c (alu_c),
    .v (alu_v)
  );
  assign is_shift = lf[2:1] == 2'b11;
  assign sh_r = lf[0] ? {ROT & la[0], la[WIDTH-1:1]} : {la[WIDTH-2:0], ROT & la[WIDTH-1]};
  assign sh_c = lf[0] ? la[0] : la[WIDTH-1];
  assign fin_r = (state == SHIFT) ? sh_r : alu_r;
  assign busy = (state == EXEC) || (state == SHIFT);
  assign done = state == DONE;
  // next-state: shifts with a nonzero count detour through SHIFT, everything else goes straight to DONE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? EXEC : IDLE;
      EXEC:    nxt = (is_shift && cnt != 3'd0) ? SHIFT : DONE;
      SHIFT:   nxt = (cnt == 3'd1) ? DONE : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end
  // operand latch, in-place shifting, and an atomic result/flag load on the edge entering DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      la     <= '0;
      lb     <= '0;
      lf     <= '0;
      cnt    <= '0;
      result <= '0;
      C      <= 1'b0;
      V      <= 1'b0;
      S      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        la  <= a;
        lb  <= b;
        lf  <= fsel;
        cnt <= count;
      end
      if (state == SHIFT) begin
        la  <= sh_r;
        cnt <= cnt - 3'd1;
      end
      if (nxt == DONE) begin
        result <= fin_r;
        C      <= (state == SHIFT) ? sh_c : alu_c;
        V      <= (state == SHIFT) ? 1'b0 : alu_v;
        S      <= fin_r[WIDTH-1];
        Z      <= fin_r == '0;
      end
    end
  end
endmodule
